port_share_rr_arbiter: RTL and testbench

- Shares one downstream single-port datapath between NUM_REQ upstream requesters.
- Uses round-robin arbitration with packet lock: a grant is held from the first beat through the beat flagged last.
- Sits between the requester blocks and the shared consumer instance in the top level.
- The only storage is the arbitration state; there is no data buffering. In lock, the datapath is a combinational mux.

---
 rtl/port_share_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_port_share_rr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/port_share_rr_arbiter.sv
// Round-robin arbiter with packet lock sharing one downstream port among NUM_REQ requesters.
// Optional stall timeout is enabled by defining PORT_SHARE_ARB_TIMEOUT_EN.
module port_share_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy,
    output logic                      timeout_pulse
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   next_ptr;
    logic            found;
    logic            g_valid;
    logic            g_last;
    logic            handshake;
    logic            timeout_fire;

    // First valid requester searching upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    assign g_valid   = req_valid[grant_id_q];
    assign g_last    = req_last[grant_id_q];
    assign handshake = (state_q == LOCKED) && g_valid && out_ready;
    assign next_ptr  = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef PORT_SHARE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    assign timeout_fire = (state_q == LOCKED) && !g_valid && (stall_cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != LOCKED || g_valid || timeout_fire) stall_cnt_d = '0;
        else                                              stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_fire   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    state_d    = LOCKED;
                end
            end
            LOCKED: begin
                if ((handshake && g_last) || timeout_fire) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Locked datapath is a pure mux; everything reads zero outside LOCKED.
    always_comb begin
        req_ready     = '0;
        out_valid     = 1'b0;
        out_data      = '0;
        out_last      = 1'b0;
        busy          = (state_q == LOCKED);
        timeout_pulse = timeout_fire;
        grant_id      = grant_id_q;
        if (state_q == LOCKED) begin
            req_ready[grant_id_q] = out_ready;
            out_valid             = g_valid;
            if (g_valid) begin
                out_data = req_data[grant_id_q*DATA_W +: DATA_W];
                out_last = g_last;
            end
        end
    end
endmodule

// File: tb/tb_port_share_rr_arbiter.sv
// Directed self-checking bench for port_share_rr_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT=15).
// The stall test follows PORT_SHARE_ARB_TIMEOUT_EN to pick its expectations.
module tb_port_share_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic                      out_ready;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    port_share_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        req_data = 32'hDDCCBBAA;
        #12;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_checks++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_pulse); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        cyc();
    endtask

    // Requester 2 sends a 3-beat packet; rr_ptr then sits at 3.
    task automatic test_single_packet();
        req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b1; set_data(2, 8'hA0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL pkt_idle: got valid=%b ready=%b want 0/0000", out_valid, req_ready); end
        cyc();
        @(negedge clk);
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL pkt_grant: got %0d want 2", grant_id); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pkt_busy: got %b want 1", busy); end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL pkt_ready: got %b want 0100", req_ready); end
        n_checks++; if (out_data !== 8'hA0 || out_last !== 1'b0) begin n_fail++; $display("FAIL pkt_beat0: got %h/%b want a0/0", out_data, out_last); end
        cyc(); set_data(2, 8'hA1);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin n_fail++; $display("FAIL pkt_beat1: got %b/%h want 1/a1", out_valid, out_data); end
        cyc(); set_data(2, 8'hA2); req_last = 4'b0100;
        @(negedge clk);
        n_checks++; if (out_data !== 8'hA2 || out_last !== 1'b1) begin n_fail++; $display("FAIL pkt_beat2: got %h/%b want a2/1", out_data, out_last); end
        cyc(); req_valid = 4'b1001; req_last = 4'b1001; set_data(3, 8'h33); set_data(0, 8'h0F);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pkt_busy_drop: got %b want 0", busy); end
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL pkt_recent_owner: got %0d want 2", grant_id); end
        cyc();
        @(negedge clk);
        n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL pkt_rr_ptr3: got %0d want 3", grant_id); end
        n_checks++; if (out_data !== 8'h33 || out_last !== 1'b1) begin n_fail++; $display("FAIL pkt_single_beat: got %h/%b want 33/1", out_data, out_last); end
        cyc(); req_valid = '0; req_last = '0;
    endtask

    // rr_ptr wrapped to 0; every requester has one-beat packets.
    task automatic test_round_robin();
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(8'h10 + i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_bubble%0d: got busy=%b want 0", k, busy); end
            cyc();
            @(negedge clk);
            n_checks++; if (grant_id !== order[k]) begin n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", k, grant_id, order[k]); end
            n_checks++; if (out_data !== 8'(8'h10 + order[k])) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", k, out_data, 8'(8'h10 + order[k])); end
            cyc();
        end
        req_valid = '0; req_last = '0;
        cyc();
    endtask

    // rr_ptr is 1; owner 1 is stalled downstream for 5 cycles mid-packet.
    task automatic test_backpressure();
        req_valid = 4'b0010; req_last = 4'b0000; out_ready = 1'b1; set_data(1, 8'h55);
        cyc();
        @(negedge clk);
        n_checks++; if (grant_id !== 2'd1 || out_data !== 8'h55) begin n_fail++; $display("FAIL bp_grant: got %0d/%h want 1/55", grant_id, out_data); end
        cyc(); set_data(1, 8'h66); out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall%0d: got valid=%b ready=%b want 1/0000", k, out_valid, req_ready); end
            n_checks++; if (out_data !== 8'h66 || grant_id !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got %h/%0d/%b want 66/1/1", k, out_data, grant_id, busy); end
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0010 || out_data !== 8'h66) begin n_fail++; $display("FAIL bp_resume: got %b/%h want 0010/66", req_ready, out_data); end
        cyc(); set_data(1, 8'h77); req_last = 4'b0010;
        @(negedge clk);
        n_checks++; if (out_data !== 8'h77 || out_last !== 1'b1) begin n_fail++; $display("FAIL bp_last: got %h/%b want 77/1", out_data, out_last); end
        cyc(); req_valid = '0; req_last = '0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", busy); end
        cyc();
    endtask

    // rr_ptr is 2; only requester 1 valid, so the search wraps. Reset hits beat 2.
    task automatic test_reset_mid_packet();
        req_valid = 4'b0010; req_last = 4'b0000; out_ready = 1'b1; set_data(1, 8'h81);
        cyc();
        @(negedge clk);
        n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL rstmid_wrap_grant: got %0d want 1", grant_id); end
        cyc(); set_data(1, 8'h82);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got busy=%b valid=%b want 0/0", busy, out_valid); end
        n_checks++; if (grant_id !== 2'd0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %0d/%b want 0/0000", grant_id, req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 4'b1000; req_last = 4'b1000; set_data(3, 8'h3C);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b want 0", busy); end
        cyc();
        @(negedge clk);
        n_checks++; if (grant_id !== 2'd3 || out_data !== 8'h3C) begin n_fail++; $display("FAIL rstmid_regrant: got %0d/%h want 3/3c", grant_id, out_data); end
        cyc(); req_valid = '0; req_last = '0;
        cyc();
    endtask

    // rr_ptr is 0; owner 0 drops valid after beat 1 while requester 2 waits.
    task automatic test_stall();
        req_valid = 4'b0101; req_last = 4'b0000; out_ready = 1'b1;
        set_data(0, 8'h5A); set_data(2, 8'h2B);
        cyc();
        @(negedge clk);
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL stall_grant: got %0d want 0", grant_id); end
        cyc(); req_valid = 4'b0100;
`ifdef PORT_SHARE_ARB_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            n_checks++; if (timeout_pulse !== (k == TIMEOUT)) begin n_fail++; $display("FAIL to_pulse%0d: got %b want %b", k, timeout_pulse, (k == TIMEOUT)); end
            n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL to_hold%0d: got %b/%0d want 1/0", k, busy, grant_id); end
            cyc();
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b/%b want 0/0", busy, timeout_pulse); end
        cyc();
        @(negedge clk);
        n_checks++; if (grant_id !== 2'd2 || out_data !== 8'h2B) begin n_fail++; $display("FAIL to_next_grant: got %0d/%h want 2/2b", grant_id, out_data); end
        req_last = 4'b0100;
        cyc();
`else
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL hold%0d: got %b/%0d want 1/0", k, busy, grant_id); end
            n_checks++; if (timeout_pulse !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL hold_out%0d: got %b/%b/%h want 0/0/00", k, timeout_pulse, out_valid, out_data); end
            cyc();
        end
        req_valid = 4'b0101; req_last = 4'b0001;
        @(negedge clk);
        n_checks++; if (out_data !== 8'h5A || out_last !== 1'b1) begin n_fail++; $display("FAIL hold_finish: got %h/%b want 5a/1", out_data, out_last); end
        cyc();
`endif
        req_valid = '0; req_last = '0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_reset_mid_packet();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
